// File: rtl/issue_queue_select_pkg.sv
// Scheduler types shared by the issue queue, its age matrix and its dispatch/issue interface.
package issue_queue_select_pkg;

  localparam int unsigned ENTRY_NUM      = 16;
  localparam int unsigned DISPATCH_WIDTH = 2;
  localparam int unsigned WAKEUP_WIDTH   = 2;
  localparam int unsigned PREG_W         = 7;
  localparam int unsigned PAYLOAD_W      = 64;
  localparam int unsigned IDX_W          = $clog2(ENTRY_NUM);
  localparam int unsigned CNT_W          = IDX_W + 1;

  typedef logic [IDX_W-1:0]     IssueQueueIndexPath;
  typedef logic [PREG_W-1:0]    PhyRegNumPath;
  typedef logic [ENTRY_NUM-1:0] entry_vec_t;

  // Operand tracking state of one slot; payload lives in a separate RAM.
  typedef struct packed {
    logic         ready_a;
    logic         ready_b;
    PhyRegNumPath src_a;
    PhyRegNumPath src_b;
  } iq_src_t;

  function automatic logic tag_hit(PhyRegNumPath src, logic [WAKEUP_WIDTH-1:0] wv,
                                   PhyRegNumPath [WAKEUP_WIDTH-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int unsigned w = 0; w < WAKEUP_WIDTH; w++) begin
      hit = hit | (wv[w] && (tags[w] == src));
    end
    return hit;
  endfunction

  function automatic IssueQueueIndexPath onehot_to_idx(entry_vec_t oh);
    IssueQueueIndexPath idx;
    idx = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(entry_vec_t v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/issue_queue_select_if.sv
// Dispatch write, wakeup broadcast, issue handshake and slot-release bundle of the issue queue.
interface issue_queue_select_if;
  import issue_queue_select_pkg::*;

  logic [DISPATCH_WIDTH-1:0]                 write;
  IssueQueueIndexPath [DISPATCH_WIDTH-1:0]   writePtr;
  logic [DISPATCH_WIDTH-1:0]                 writeSrcValidA;
  logic [DISPATCH_WIDTH-1:0]                 writeSrcValidB;
  PhyRegNumPath [DISPATCH_WIDTH-1:0]         writeSrcA;
  PhyRegNumPath [DISPATCH_WIDTH-1:0]         writeSrcB;
  logic [DISPATCH_WIDTH-1:0][PAYLOAD_W-1:0]  writePayload;
  logic [WAKEUP_WIDTH-1:0]                   wakeupValid;
  PhyRegNumPath [WAKEUP_WIDTH-1:0]           wakeupTag;
  logic                                      issueValid;
  logic                                      issueReady;
  IssueQueueIndexPath                        issuePtr;
  logic [PAYLOAD_W-1:0]                      issuePayload;
  logic                                      releaseValid;
  IssueQueueIndexPath                        releasePtr;
  logic [CNT_W-1:0]                          occupancy;

  modport master (
    output write, writePtr, writeSrcValidA, writeSrcValidB, writeSrcA, writeSrcB,
           writePayload, wakeupValid, wakeupTag, issueReady,
    input  issueValid, issuePtr, issuePayload, releaseValid, releasePtr, occupancy
  );

  modport slave (
    input  write, writePtr, writeSrcValidA, writeSrcValidB, writeSrcA, writeSrcB,
           writePayload, wakeupValid, wakeupTag, issueReady,
    output issueValid, issuePtr, issuePayload, releaseValid, releasePtr, occupancy
  );

endinterface

// File: rtl/issue_queue_age_matrix.sv
// Relative-age matrix: row i has bit j set when slot j is older than slot i; grants the oldest candidate.
module issue_queue_age_matrix
  import issue_queue_select_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [DISPATCH_WIDTH-1:0]               we,
  input  IssueQueueIndexPath [DISPATCH_WIDTH-1:0] wptr,
  input  entry_vec_t                              valid,
  input  entry_vec_t                              cand,
  output entry_vec_t                              grant_c
);

  entry_vec_t age_q [ENTRY_NUM];
  entry_vec_t age_d [ENTRY_NUM];
  entry_vec_t older;

  // A new entry is younger than everything valid plus lower lanes of the same cycle.
  always_comb begin
    for (int unsigned r = 0; r < ENTRY_NUM; r++) begin
      age_d[r] = flush ? '0 : age_q[r];
    end
    older = valid;
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      if (we[k]) begin
        for (int unsigned r = 0; r < ENTRY_NUM; r++) begin
          age_d[r][wptr[k]] = 1'b0;
        end
        age_d[wptr[k]] = older;
        older[wptr[k]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      grant_c[i] = cand[i] & ~(|(age_q[i] & cand));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < ENTRY_NUM; r++) age_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < ENTRY_NUM; r++) age_q[r] <= age_d[r];
    end
  end

endmodule

// File: rtl/issue_queue_select.sv
// Issue queue: accepts dispatched entries, tracks operand wakeup, issues the oldest ready entry.
module issue_queue_select
  import issue_queue_select_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  issue_queue_select_if.slave  iq
);

  entry_vec_t            valid_q, valid_d, cand, grant;
  iq_src_t               ent_q [ENTRY_NUM];
  iq_src_t               ent_d [ENTRY_NUM];
  logic [PAYLOAD_W-1:0]  payload_q [ENTRY_NUM];
  logic [DISPATCH_WIDTH-1:0] we;
  logic                  sel_en, fire, wr_illegal;
  IssueQueueIndexPath    win_idx;

  logic                  issue_valid_q, release_valid_q;
  IssueQueueIndexPath    issue_ptr_q, release_ptr_q;
  logic [PAYLOAD_W-1:0]  issue_payload_q;
  logic [CNT_W-1:0]      occupancy_q;

  assign we      = flush ? '0 : iq.write;
  assign sel_en  = !issue_valid_q || iq.issueReady;
  assign fire    = sel_en && (|grant);
  assign win_idx = onehot_to_idx(grant);

  always_comb begin
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      cand[i] = valid_q[i] & ent_q[i].ready_a & ent_q[i].ready_b;
    end
  end

  issue_queue_age_matrix u_age (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .we      (we),
    .wptr    (iq.writePtr),
    .valid   (valid_q),
    .cand    (cand),
    .grant_c (grant)
  );

  // Wakeup on resident entries, then new writes (which see this cycle's tags too).
  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      ent_d[i] = ent_q[i];
      ent_d[i].ready_a = ent_q[i].ready_a | tag_hit(ent_q[i].src_a, iq.wakeupValid, iq.wakeupTag);
      ent_d[i].ready_b = ent_q[i].ready_b | tag_hit(ent_q[i].src_b, iq.wakeupValid, iq.wakeupTag);
    end
    if (fire) valid_d[win_idx] = 1'b0;
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      if (we[k]) begin
        valid_d[iq.writePtr[k]]       = 1'b1;
        ent_d[iq.writePtr[k]].src_a   = iq.writeSrcA[k];
        ent_d[iq.writePtr[k]].src_b   = iq.writeSrcB[k];
        ent_d[iq.writePtr[k]].ready_a = !iq.writeSrcValidA[k] ||
                                        tag_hit(iq.writeSrcA[k], iq.wakeupValid, iq.wakeupTag);
        ent_d[iq.writePtr[k]].ready_b = !iq.writeSrcValidB[k] ||
                                        tag_hit(iq.writeSrcB[k], iq.wakeupValid, iq.wakeupTag);
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q         <= '0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) ent_q[i] <= '0;
      issue_valid_q   <= 1'b0;
      issue_ptr_q     <= '0;
      issue_payload_q <= '0;
      release_valid_q <= 1'b0;
      release_ptr_q   <= '0;
      occupancy_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) ent_q[i] <= ent_d[i];
      occupancy_q <= popcount(valid_d);
      if (flush) begin
        issue_valid_q   <= 1'b0;
        release_valid_q <= 1'b0;
      end else if (sel_en) begin
        issue_valid_q   <= fire;
        release_valid_q <= fire;
        if (fire) begin
          issue_ptr_q     <= win_idx;
          issue_payload_q <= payload_q[win_idx];
          release_ptr_q   <= win_idx;
        end
      end else begin
        release_valid_q <= 1'b0;
      end
    end
  end

  // Payload storage is plain RAM; validity is tracked separately so it needs no reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      if (we[k]) payload_q[iq.writePtr[k]] <= iq.writePayload[k];
    end
  end

  always_comb begin
    wr_illegal = 1'b0;
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      if (we[k]) begin
        if (valid_q[iq.writePtr[k]]) wr_illegal = 1'b1;
        for (int unsigned j = 0; j < k; j++) begin
          if (we[j] && (iq.writePtr[j] == iq.writePtr[k])) wr_illegal = 1'b1;
        end
      end
    end
  end

  a_write_legal: assert property (@(posedge clk) disable iff (!rst) !wr_illegal);

  assign iq.issueValid   = issue_valid_q;
  assign iq.issuePtr     = issue_ptr_q;
  assign iq.issuePayload = issue_payload_q;
  assign iq.releaseValid = release_valid_q;
  assign iq.releasePtr   = release_ptr_q;
  assign iq.occupancy    = occupancy_q;

endmodule

// File: tb/tb_issue_queue_select.sv
// Directed bench for issue_queue_select: dispatch, wakeup, age-ordered issue, backpressure, flush.
module tb_issue_queue_select;
  import issue_queue_select_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  issue_queue_select_if iq();

  issue_queue_select dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .iq    (iq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iq.write          = '0;
    iq.writePtr       = '0;
    iq.writeSrcValidA = '0;
    iq.writeSrcValidB = '0;
    iq.writeSrcA      = '0;
    iq.writeSrcB      = '0;
    iq.writePayload   = '0;
    iq.wakeupValid    = '0;
    iq.wakeupTag      = '0;
  endtask

  task automatic put(input logic lane, input IssueQueueIndexPath ptr,
                     input logic va, input PhyRegNumPath a,
                     input logic vb, input PhyRegNumPath b,
                     input logic [PAYLOAD_W-1:0] pl);
    iq.write[lane]          = 1'b1;
    iq.writePtr[lane]       = ptr;
    iq.writeSrcValidA[lane] = va;
    iq.writeSrcA[lane]      = a;
    iq.writeSrcValidB[lane] = vb;
    iq.writeSrcB[lane]      = b;
    iq.writePayload[lane]   = pl;
  endtask

  task automatic wake(input logic lane, input PhyRegNumPath tag);
    iq.wakeupValid[lane] = 1'b1;
    iq.wakeupTag[lane]   = tag;
  endtask

  task automatic test_reset();
    logic [6:0]  s_got;
    logic [63:0] p_got;
    rst = 1'b1; flush = 1'b0; iq.issueReady = 1'b1; idle();
    #2 rst = 1'b0;
    #20;
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy};
    checks++; if (s_got !== 7'd0) begin errors++; $display("FAIL reset_flags got=%h exp=%h", s_got, 7'd0); end
    checks++; if (iq.issuePtr !== 4'd0) begin errors++; $display("FAIL reset_ptr got=%h exp=0", iq.issuePtr); end
    p_got = iq.issuePayload;
    checks++; if (p_got !== 64'd0) begin errors++; $display("FAIL reset_payload got=%h exp=0", p_got); end
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [6:0] s_got, s_exp; logic [14:0] f_got, f_exp;
    put(1'b0, 4'd3, 1'b0, 7'd0, 1'b0, 7'd0, 64'hA3);
    tick(); idle();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy}; s_exp = {1'b0, 1'b0, 5'd1};
    checks++; if (s_got !== s_exp) begin errors++; $display("FAIL single_written got=%h exp=%h", s_got, s_exp); end
    tick();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd3, 1'b1, 4'd3, 5'd0};
    checks++; if (f_got !== f_exp) begin errors++; $display("FAIL single_issue got=%h exp=%h", f_got, f_exp); end
    checks++; if (iq.issuePayload !== 64'hA3) begin errors++; $display("FAIL single_payload got=%h exp=a3", iq.issuePayload); end
    tick();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy};
    checks++; if (s_got !== 7'd0) begin errors++; $display("FAIL single_drain got=%h exp=%h", s_got, 7'd0); end
  endtask

  task automatic test_wakeup();
    logic [6:0] s_got, s_exp; logic [14:0] f_got, f_exp;
    put(1'b0, 4'd5, 1'b1, 7'd20, 1'b0, 7'd0, 64'hB5);
    tick(); idle();
    tick(); tick();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy}; s_exp = {1'b0, 1'b0, 5'd1};
    checks++; if (s_got !== s_exp) begin errors++; $display("FAIL wakeup_waiting got=%h exp=%h", s_got, s_exp); end
    wake(1'b0, 7'd21); wake(1'b1, 7'd20);
    tick(); idle();
    checks++; if (s_got !== s_exp) begin errors++; $display("FAIL wakeup_t1 got=%h exp=%h", s_got, s_exp); end
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy};
    checks++; if (s_got !== s_exp) begin errors++; $display("FAIL wakeup_t1_live got=%h exp=%h", s_got, s_exp); end
    tick();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd5, 1'b1, 4'd5, 5'd0};
    checks++; if (f_got !== f_exp) begin errors++; $display("FAIL wakeup_issue got=%h exp=%h", f_got, f_exp); end
    checks++; if (iq.issuePayload !== 64'hB5) begin errors++; $display("FAIL wakeup_payload got=%h exp=b5", iq.issuePayload); end
    tick();
  endtask

  task automatic test_age_order();
    logic [6:0] s_got, s_exp; logic [14:0] f_got, f_exp;
    put(1'b0, 4'd7, 1'b0, 7'd0, 1'b0, 7'd0, 64'hC7);
    put(1'b1, 4'd2, 1'b0, 7'd0, 1'b0, 7'd0, 64'hC2);
    tick(); idle();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy}; s_exp = {1'b0, 1'b0, 5'd2};
    checks++; if (s_got !== s_exp) begin errors++; $display("FAIL age_written got=%h exp=%h", s_got, s_exp); end
    tick();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd7, 1'b1, 4'd7, 5'd1};
    checks++; if (f_got !== f_exp) begin errors++; $display("FAIL age_first got=%h exp=%h", f_got, f_exp); end
    checks++; if (iq.issuePayload !== 64'hC7) begin errors++; $display("FAIL age_first_payload got=%h exp=c7", iq.issuePayload); end
    tick();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd2, 1'b1, 4'd2, 5'd0};
    checks++; if (f_got !== f_exp) begin errors++; $display("FAIL age_second got=%h exp=%h", f_got, f_exp); end
    checks++; if (iq.issuePayload !== 64'hC2) begin errors++; $display("FAIL age_second_payload got=%h exp=c2", iq.issuePayload); end
    tick();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy};
    checks++; if (s_got !== 7'd0) begin errors++; $display("FAIL age_drain got=%h exp=%h", s_got, 7'd0); end
  endtask

  task automatic test_backpressure();
    logic [6:0] s_got, s_exp; logic [14:0] f_got, f_exp;
    iq.issueReady = 1'b0;
    put(1'b0, 4'd4, 1'b0, 7'd0, 1'b0, 7'd0, 64'hD4);
    put(1'b1, 4'd6, 1'b0, 7'd0, 1'b0, 7'd0, 64'hD6);
    tick(); idle();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy}; s_exp = {1'b0, 1'b0, 5'd2};
    checks++; if (s_got !== s_exp) begin errors++; $display("FAIL hold_written got=%h exp=%h", s_got, s_exp); end
    put(1'b0, 4'd9, 1'b0, 7'd0, 1'b0, 7'd0, 64'hD9);
    tick(); idle();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd4, 1'b1, 4'd4, 5'd2};
    checks++; if (f_got !== f_exp) begin errors++; $display("FAIL hold_first got=%h exp=%h", f_got, f_exp); end
    for (int c = 0; c < 4; c++) begin
      tick();
      s_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.occupancy[0]};
      s_exp = {1'b1, 4'd4, 1'b0, 1'b0};
      checks++; if (s_got !== s_exp || iq.occupancy !== 5'd2 || iq.issuePayload !== 64'hD4) begin
        errors++;
        $display("FAIL hold_stall%0d got=%h/%h/%h exp=%h/02/d4", c, s_got, iq.occupancy, iq.issuePayload, s_exp);
      end
    end
    iq.issueReady = 1'b1;
    tick();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd6, 1'b1, 4'd6, 5'd1};
    checks++; if (f_got !== f_exp) begin errors++; $display("FAIL hold_resume6 got=%h exp=%h", f_got, f_exp); end
    tick();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd9, 1'b1, 4'd9, 5'd0};
    checks++; if (f_got !== f_exp) begin errors++; $display("FAIL hold_resume9 got=%h exp=%h", f_got, f_exp); end
    checks++; if (iq.issuePayload !== 64'hD9) begin errors++; $display("FAIL hold_payload9 got=%h exp=d9", iq.issuePayload); end
    tick();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy};
    checks++; if (s_got !== 7'd0) begin errors++; $display("FAIL hold_drain got=%h exp=%h", s_got, 7'd0); end
  endtask

  task automatic test_same_cycle_wakeup();
    logic [6:0] s_got, s_exp; logic [14:0] f_got, f_exp;
    put(1'b0, 4'd1, 1'b0, 7'd0, 1'b1, 7'd9, 64'hE1);
    wake(1'b0, 7'd9);
    tick(); idle();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy}; s_exp = {1'b0, 1'b0, 5'd1};
    checks++; if (s_got !== s_exp) begin errors++; $display("FAIL samewake_written got=%h exp=%h", s_got, s_exp); end
    tick();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd1, 1'b1, 4'd1, 5'd0};
    checks++; if (f_got !== f_exp) begin errors++; $display("FAIL samewake_issue got=%h exp=%h", f_got, f_exp); end
    tick();
  endtask

  task automatic test_flush();
    logic [6:0] s_got, s_exp; logic [14:0] f_got, f_exp;
    iq.issueReady = 1'b0;
    for (int c = 0; c < 8; c++) begin
      put(1'b0, IssueQueueIndexPath'(2 * c), (c != 0), 7'd100, 1'b0, 7'd0, 64'hF0 + 64'(2 * c));
      put(1'b1, IssueQueueIndexPath'(2 * c + 1), 1'b1, 7'd100, 1'b0, 7'd0, 64'hF1 + 64'(2 * c));
      tick(); idle();
    end
    put(1'b0, 4'd0, 1'b1, 7'd100, 1'b0, 7'd0, 64'hF0);
    tick(); idle();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr[0], iq.occupancy};
    f_exp = {1'b1, 4'd0, 1'b0, 1'b0, 5'd16};
    f_got[5] = 1'b0;
    checks++; if (f_got !== f_exp || iq.issuePayload !== 64'hF0) begin
      errors++; $display("FAIL flush_full got=%h/%h exp=%h/f0", f_got, iq.issuePayload, f_exp);
    end
    flush = 1'b1;
    put(1'b0, 4'd5, 1'b0, 7'd0, 1'b0, 7'd0, 64'hDEAD);
    tick(); flush = 1'b0; idle(); iq.issueReady = 1'b1;
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy};
    checks++; if (s_got !== 7'd0) begin errors++; $display("FAIL flush_clear got=%h exp=%h", s_got, 7'd0); end
    tick();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy};
    checks++; if (s_got !== 7'd0) begin errors++; $display("FAIL flush_write_dropped got=%h exp=%h", s_got, 7'd0); end
    wake(1'b0, 7'd100);
    tick(); idle(); tick();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy};
    checks++; if (s_got !== 7'd0) begin errors++; $display("FAIL flush_no_stale got=%h exp=%h", s_got, 7'd0); end
    put(1'b1, 4'd0, 1'b0, 7'd0, 1'b0, 7'd0, 64'h0A);
    tick(); idle();
    s_got = {iq.issueValid, iq.releaseValid, iq.occupancy}; s_exp = {1'b0, 1'b0, 5'd1};
    checks++; if (s_got !== s_exp) begin errors++; $display("FAIL flush_reuse_write got=%h exp=%h", s_got, s_exp); end
    tick();
    f_got = {iq.issueValid, iq.issuePtr, iq.releaseValid, iq.releasePtr, iq.occupancy};
    f_exp = {1'b1, 4'd0, 1'b1, 4'd0, 5'd0};
    checks++; if (f_got !== f_exp || iq.issuePayload !== 64'h0A) begin
      errors++; $display("FAIL flush_reuse_issue got=%h/%h exp=%h/0a", f_got, iq.issuePayload, f_exp);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wakeup();
    test_age_order();
    test_backpressure();
    test_same_cycle_wakeup();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
